// File: rtl/dadda_final_adder_pipe.sv
// Final carry-propagate adder of the 16x16 Dadda multiplier: adds the sum and
// carry rows CHUNK bits per pipeline stage. Define CARRY_OUT_EN to expose cout.
module dadda_final_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] row_s,
  input  logic [WIDTH-1:0] row_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product
`ifdef CARRY_OUT_EN
  ,
  output logic             cout
`endif
);

  localparam int STAGES = WIDTH / CHUNK;
`ifdef CARRY_OUT_EN
  localparam bit HAS_COUT = 1'b1;
`else
  localparam bit HAS_COUT = 1'b0;
`endif

  if ((WIDTH % CHUNK) != 0 || STAGES < 2) begin : g_bad_cfg
    $error("dadda_final_adder_pipe: WIDTH must be a multiple of CHUNK with at least two chunks");
  end

  // The whole pipe moves in lockstep; a bubble at the output never blocks it.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SRC_W = WIDTH - k * CHUNK;  // bits of each row not yet added
    localparam int REM_W = SRC_W - CHUNK;      // bits handed on to later stages
    localparam int DONE_W = (k + 1) * CHUNK;   // finished product bits
    // The last stage keeps its carry only when it is exported.
    localparam bit KEEP_CARRY = (k < STAGES - 1) || HAS_COUT;
    localparam int SUM_W = KEEP_CARRY ? CHUNK + 1 : CHUNK;

    logic [SRC_W-1:0]  src_s;
    logic [SRC_W-1:0]  src_c;
    logic              cin;
    logic              vin;
    logic [SUM_W-1:0]  sum;
    logic [DONE_W-1:0] done_nxt;
    logic              vld_q;
    logic [DONE_W-1:0] done_q;

    if (k == 0) begin : g_head
      assign src_s    = row_s;
      assign src_c    = row_c;
      assign cin      = 1'b0;
      assign vin      = in_valid;
      assign done_nxt = sum[CHUNK-1:0];
    end else begin : g_body
      assign src_s    = g_stage[k-1].g_rem.rs_q;
      assign src_c    = g_stage[k-1].g_rem.rc_q;
      assign cin      = g_stage[k-1].g_rem.carry_q;
      assign vin      = g_stage[k-1].vld_q;
      assign done_nxt = {sum[CHUNK-1:0], g_stage[k-1].done_q};
    end

    always_comb begin
      sum = SUM_W'(src_s[CHUNK-1:0]) + SUM_W'(src_c[CHUNK-1:0]) + SUM_W'(cin);
    end

    // NOTE: registers use non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        done_q <= '0;
      end else if (adv) begin
        vld_q  <= vin;
        done_q <= done_nxt;
      end
    end

    if (REM_W > 0) begin : g_rem
      logic [REM_W-1:0] rs_q;
      logic [REM_W-1:0] rc_q;
      logic             carry_q;

      // NOTE: data registers are reset too, so product reads 0 after reset
      // rather than whatever was in flight.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rs_q    <= '0;
          rc_q    <= '0;
          carry_q <= 1'b0;
        end else if (adv) begin
          rs_q    <= src_s[SRC_W-1:CHUNK];
          rc_q    <= src_c[SRC_W-1:CHUNK];
          carry_q <= sum[CHUNK];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign product   = g_stage[STAGES-1].done_q;

`ifdef CARRY_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout <= 1'b0;
    end else if (adv) begin
      cout <= g_stage[STAGES-1].sum[CHUNK];
    end
  end
`endif

endmodule
